// File: rtl/xor_parity_pkg.sv
// Shared types and the row-parity rule for the 2-D XOR parity receive path.
package xor_parity_pkg;

    localparam int CNT_W_MAX  = 16;
    localparam int DATA_W_MAX = 64;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    typedef struct packed {
        logic [CNT_W_MAX-1:0] beats;
        logic [CNT_W_MAX-1:0] row_errs;
        logic [CNT_W_MAX-1:0] first_bad;
        logic                 col_ok;
        logic                 overflow;
    } result_t;

    // Narrow data is zero-extended by the caller; zero bits do not change the XOR.
    function automatic logic row_par_ok(input logic [DATA_W_MAX-1:0] data,
                                        input logic                  par,
                                        input logic                  odd);
        return odd ? (par == ~^data) : (par == ^data);
    endfunction

endpackage

// File: rtl/xor_parity_checker_row_check.sv
// Combinational row-parity check of one beat; shared with the generator-side self-test.
module xor_row_check
    import xor_parity_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int ODD   = 0
) (
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    output logic             row_ok
);

    assign row_ok = row_par_ok(DATA_W_MAX'(in_data), in_par, ODD != 0);

endmodule

// File: rtl/xor_parity_checker.sv
// Receive-side 2-D XOR parity checker: per-beat row check, LRC column check, one record per frame.
module xor_parity_checker
    import xor_parity_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MAX_BEATS = 16,
    parameter int ODD       = 0,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CW-1:0]    res_beats,
    output logic [CW-1:0]    res_row_errs,
    output logic [CW-1:0]    res_first_bad,
    output logic             res_col_ok,
    output logic             res_overflow
);

    state_t           state, state_d;
    logic [WIDTH-1:0] col_acc, col_acc_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [CW-1:0]    row_errs, row_errs_d;
    logic [CW-1:0]    first_bad, first_bad_d;
    result_t          res_q, res_d;

    logic             row_ok;
    logic             row_fail;
    logic             accept;
    logic             term;
    logic [CW-1:0]    errs_next;
    logic [CW-1:0]    first_next;
    logic             unused_res_bits;

    xor_row_check #(
        .WIDTH (WIDTH),
        .ODD   (ODD)
    ) u_row_check (
        .in_data (in_data),
        .in_par  (in_par),
        .row_ok  (row_ok)
    );

    assign in_ready   = (state == ACCUM) | ((state == REPORT) & res_ready);
    assign accept     = in_valid & in_ready;
    // A frame that reaches MAX_BEATS without in_last is cut here and flagged as overflow.
    assign term       = in_last | (cnt == CW'(MAX_BEATS - 1));
    assign row_fail   = ~row_ok;
    assign errs_next  = row_errs + CW'(row_fail);
    assign first_next = (row_fail && (row_errs == '0)) ? cnt : first_bad;

    always_comb begin
        state_d     = state;
        col_acc_d   = col_acc;
        cnt_d       = cnt;
        row_errs_d  = row_errs;
        first_bad_d = first_bad;
        res_d       = res_q;

        if ((state == REPORT) && res_ready) begin
            state_d = ACCUM;
        end

        if (accept) begin
            if (term) begin
                res_d.beats     = CNT_W_MAX'(cnt + CW'(1));
                res_d.row_errs  = CNT_W_MAX'(errs_next);
                res_d.first_bad = CNT_W_MAX'(first_next);
                res_d.col_ok    = in_last & (in_data == col_acc);
                res_d.overflow  = ~in_last;
                state_d         = REPORT;
                col_acc_d       = '0;
                cnt_d           = '0;
                row_errs_d      = '0;
                first_bad_d     = '0;
            end else begin
                col_acc_d   = col_acc ^ in_data;
                cnt_d       = cnt + CW'(1);
                row_errs_d  = errs_next;
                first_bad_d = first_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            col_acc   <= '0;
            cnt       <= '0;
            row_errs  <= '0;
            first_bad <= '0;
            res_q     <= '0;
        end else begin
            state     <= state_d;
            col_acc   <= col_acc_d;
            cnt       <= cnt_d;
            row_errs  <= row_errs_d;
            first_bad <= first_bad_d;
            res_q     <= res_d;
        end
    end

    assign res_valid     = (state == REPORT);
    assign res_beats     = res_q.beats[CW-1:0];
    assign res_row_errs  = res_q.row_errs[CW-1:0];
    assign res_first_bad = res_q.first_bad[CW-1:0];
    assign res_col_ok    = res_q.col_ok;
    assign res_overflow  = res_q.overflow;

    // Record fields are wider than CW; the spare high bits are always zero.
    assign unused_res_bits = ^res_q;

endmodule

// File: tb/tb_xor_parity_checker.sv
// Bench for xor_parity_checker: directed frames plus random frames scored against a frame-list model.
module tb_xor_parity_checker;

    localparam int MB0 = 4;
    localparam int MB1 = 16;

    typedef struct {
        int beats;
        int errs;
        int first;
        int col_ok;
        int ovf;
    } rec_t;

    logic       clk;
    logic       rst_n;
    logic       iv [2];
    logic       ir [2];
    logic [4:0] id [2];
    logic       ip [2];
    logic       il [2];
    logic       rv [2];
    logic       rr [2];
    logic       rc [2];
    logic       ro [2];
    logic [4:0] rb [2];
    logic [4:0] re [2];
    logic [4:0] rf [2];
    logic [2:0] b0, e0, f0;
    logic [4:0] b1, e1, f1;

    int   n_cmp;
    int   n_bad;
    int   cur;
    logic [5:0] frm [$];
    rec_t       expq [$];

    assign rb[0] = {2'b00, b0};
    assign re[0] = {2'b00, e0};
    assign rf[0] = {2'b00, f0};
    assign rb[1] = b1;
    assign re[1] = e1;
    assign rf[1] = f1;

    xor_parity_checker #(.WIDTH(5), .MAX_BEATS(MB0), .ODD(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_par(ip[0]), .in_last(il[0]),
        .res_valid(rv[0]), .res_ready(rr[0]), .res_beats(b0), .res_row_errs(e0),
        .res_first_bad(f0), .res_col_ok(rc[0]), .res_overflow(ro[0])
    );

    xor_parity_checker #(.WIDTH(5), .MAX_BEATS(MB1), .ODD(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_par(ip[1]), .in_last(il[1]),
        .res_valid(rv[1]), .res_ready(rr[1]), .res_beats(b1), .res_row_errs(e1),
        .res_first_bad(f1), .res_col_ok(rc[1]), .res_overflow(ro[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    function automatic int max_beats(input int d);
        return (d == 0) ? MB0 : MB1;
    endfunction

    // Expected record from the complete list of beats that formed the frame.
    function automatic rec_t calc(input bit last);
        rec_t r;
        logic [4:0] x;
        int odd;
        odd = (cur == 0) ? 0 : 1;
        r.beats = frm.size();
        r.errs  = 0;
        r.first = 0;
        x = '0;
        for (int i = 0; i < frm.size(); i++) begin
            if ((($countones(frm[i][5:1]) + int'(frm[i][0])) % 2) != odd) begin
                if (r.errs == 0) r.first = i;
                r.errs++;
            end
            if (i < frm.size() - 1) x = x ^ frm[i][5:1];
        end
        r.col_ok = (last && (frm[frm.size()-1][5:1] == x)) ? 1 : 0;
        r.ovf    = last ? 0 : 1;
        return r;
    endfunction

    task automatic model_accept(input logic [4:0] d, input logic p, input logic l);
        frm.push_back({d, p});
        if (l || (frm.size() == max_beats(cur))) begin
            expq.push_back(calc(l));
            frm.delete();
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the beat.
    task automatic send_beat(input logic [4:0] d, input logic p, input logic l, input bit rnd);
        int t;
        bit ok;
        iv[cur] = 1'b1; id[cur] = d; ip[cur] = p; il[cur] = l;
        t = 0;
        ok = 1'b0;
        while (!ok && t < 60) begin
            @(negedge clk);
            if (ir[cur]) ok = 1'b1;
            else begin
                @(posedge clk); #1;
                if (rnd) rr[cur] = ($urandom_range(0, 3) != 0);
                t++;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
            model_accept(d, p, l);
        end else begin
            timeout("in_ready_wait");
        end
        iv[cur] = 1'b0;
    endtask

    task automatic drain();
        int t;
        bit done;
        rr[cur] = 1'b1;
        t = 0;
        done = 1'b0;
        while (!done && t < 60) begin
            @(negedge clk);
            if (!rv[cur]) done = 1'b1;
            t++;
        end
        if (!done) timeout("drain");
        @(posedge clk); #1;
    endtask

    task automatic chk_rec(input string tag, input int beats, input int errs, input int first,
                           input int col, input int ovf);
        chk({tag, "_valid"},  32'(rv[cur]), 1);
        chk({tag, "_beats"},  32'(rb[cur]), beats);
        chk({tag, "_errs"},   32'(re[cur]), errs);
        chk({tag, "_first"},  32'(rf[cur]), first);
        chk({tag, "_col_ok"}, 32'(rc[cur]), col);
        chk({tag, "_ovf"},    32'(ro[cur]), ovf);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        frm.delete();
        expq.delete();
        chk("rst_valid",  32'(rv[cur]), 0);
        chk("rst_beats",  32'(rb[cur]), 0);
        chk("rst_errs",   32'(re[cur]), 0);
        chk("rst_first",  32'(rf[cur]), 0);
        chk("rst_col_ok", 32'(rc[cur]), 0);
        chk("rst_ovf",    32'(ro[cur]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(ir[cur]), 1);
    endtask

    task automatic clean_frame(input logic inv);
        send_beat(5'b00011, 1'b0 ^ inv, 1'b0, 1'b0);
        send_beat(5'b10101, 1'b1 ^ inv, 1'b0, 1'b0);
        send_beat(5'b10110, 1'b1 ^ inv, 1'b1, 1'b0);
    endtask

    task automatic rand_frames(input int nfr, input int maxlen);
        int len;
        logic [4:0] d, x;
        logic p, l;
        for (int f = 0; f < nfr; f++) begin
            len = $urandom_range(1, maxlen);
            x = '0;
            for (int i = 0; i < len; i++) begin
                d = 5'($urandom);
                l = (i == len - 1);
                if (l && $urandom_range(0, 1) == 1) d = x;
                p = (cur == 0) ? ^d : ~^d;
                if ($urandom_range(0, 6) == 0) p = ~p;
                rr[cur] = ($urandom_range(0, 3) != 0);
                send_beat(d, p, l, 1'b1);
                x = x ^ d;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Scoreboard: a record is consumed on the edge that follows a negedge with valid & ready.
    always @(negedge clk) begin
        if (rst_n && rv[cur] && rr[cur]) begin
            chk("sb_expected_pending", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                rec_t e;
                e = expq.pop_front();
                chk("sb_beats",  32'(rb[cur]), e.beats);
                chk("sb_errs",   32'(re[cur]), e.errs);
                chk("sb_first",  32'(rf[cur]), e.first);
                chk("sb_col_ok", 32'(rc[cur]), e.col_ok);
                chk("sb_ovf",    32'(ro[cur]), e.ovf);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cur   = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; id[k] = '0; ip[k] = 1'b0; il[k] = 1'b0; rr[k] = 1'b1;
        end
        #2;
        do_reset();

        clean_frame(1'b0);
        chk_rec("clean", 3, 0, 0, 1, 0);

        send_beat(5'b00011, 1'b0, 1'b0, 1'b0);
        send_beat(5'b10101, 1'b0, 1'b0, 1'b0);
        send_beat(5'b10110, 1'b1, 1'b1, 1'b0);
        chk_rec("row_err", 3, 1, 1, 1, 0);

        send_beat(5'b00011, 1'b0, 1'b0, 1'b0);
        send_beat(5'b10101, 1'b1, 1'b0, 1'b0);
        send_beat(5'b10111, 1'b0, 1'b1, 1'b0);
        chk_rec("col_err", 3, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) send_beat(5'b00001, 1'b1, 1'b0, 1'b0);
        chk_rec("ovf", 4, 0, 0, 0, 1);
        send_beat(5'b00001, 1'b1, 1'b1, 1'b0);
        chk_rec("after_ovf", 1, 0, 0, 0, 0);

        drain();
        rr[0] = 1'b0;
        clean_frame(1'b0);
        iv[0] = 1'b1; id[0] = 5'b00000; ip[0] = 1'b0; il[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(ir[0]), 0);
            chk_rec("bp_hold", 3, 0, 0, 1, 0);
            @(posedge clk); #1;
        end
        rr[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(ir[0]), 1);
        @(posedge clk); #1;
        model_accept(5'b00000, 1'b0, 1'b1);
        iv[0] = 1'b0;
        chk_rec("bp_next", 1, 0, 0, 1, 0);

        drain();
        rr[0] = 1'b0;
        clean_frame(1'b0);
        chk("held_valid", 32'(rv[0]), 1);
        do_reset();
        rr[0] = 1'b1;

        send_beat(5'b11111, 1'b0, 1'b0, 1'b0);
        send_beat(5'b00111, 1'b0, 1'b0, 1'b0);
        do_reset();
        clean_frame(1'b0);
        chk_rec("post_rst", 3, 0, 0, 1, 0);

        rand_frames(40, 7);
        drain();

        cur = 1;
        clean_frame(1'b1);
        chk_rec("odd_clean", 3, 0, 0, 1, 0);
        clean_frame(1'b0);
        chk_rec("odd_even_bits", 3, 3, 0, 1, 0);
        rand_frames(30, 20);
        drain();

        chk("sb_all_consumed", 32'(expq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
